// File: rtl/vec_opnd_fetch_if.sv
// Issue, writeback, VRF-read and execute-side signals of the vector operand-fetch stage.
// The stage itself uses the slave modport; the issue/VRF/execute environment uses master.
interface vec_opnd_fetch_if #(
  parameter int XLEN  = 512,
  parameter int WPORT = 4,
  parameter int TAG_W = 8
);
  logic               iss_valid;
  logic               iss_ready;
  logic [TAG_W-1:0]   iss_tag;
  logic [3:0]         iss_use;
  logic [4:0]         iss_vs1;
  logic [4:0]         iss_vs2;
  logic [4:0]         iss_vs3;
  logic               iss_sc_en;
  logic [63:0]        iss_scalar;
  logic [1:0]         iss_sew;
  logic               iss_wb;
  logic [4:0]         iss_vd;
  logic [WPORT-1:0]   wb_valid;
  logic [WPORT*5-1:0] wb_addr;
  logic [3:0]         vrf_rd_en;
  logic [19:0]        vrf_rd_addr;
  logic [4*XLEN-1:0]  vrf_rd_data;
  logic               ex_valid;
  logic               ex_ready;
  logic [TAG_W-1:0]   ex_tag;
  logic [3:0]         ex_use;
  logic [XLEN-1:0]    ex_opnd0;
  logic [XLEN-1:0]    ex_opnd1;
  logic [XLEN-1:0]    ex_opnd2;
  logic [XLEN-1:0]    ex_mask;

  modport master (
    output iss_valid, iss_tag, iss_use, iss_vs1, iss_vs2, iss_vs3, iss_sc_en,
           iss_scalar, iss_sew, iss_wb, iss_vd, wb_valid, wb_addr, vrf_rd_data, ex_ready,
    input  iss_ready, vrf_rd_en, vrf_rd_addr, ex_valid, ex_tag, ex_use,
           ex_opnd0, ex_opnd1, ex_opnd2, ex_mask
  );

  modport slave (
    input  iss_valid, iss_tag, iss_use, iss_vs1, iss_vs2, iss_vs3, iss_sc_en,
           iss_scalar, iss_sew, iss_wb, iss_vd, wb_valid, wb_addr, vrf_rd_data, ex_ready,
    output iss_ready, vrf_rd_en, vrf_rd_addr, ex_valid, ex_tag, ex_use,
           ex_opnd0, ex_opnd1, ex_opnd2, ex_mask
  );
endinterface

// File: rtl/vec_opnd_fetch.sv
// Vector operand fetch: scoreboard hazard check, VRF read drive, one-stage operand/splat output.
// Latency 1 (accept at t -> ex_valid at t+1); stalls issue while ex holds and !ex_ready.
module vec_opnd_fetch #(
  parameter int XLEN  = 512,
  parameter int WPORT = 4,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  vec_opnd_fetch_if.slave bus
);

  logic [31:0]      busy_q, busy_d;
  logic             v_q;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]       use_q;
  logic             sc_en_q;
  logic [XLEN-1:0]  splat_q, splat_d;

  logic [3:0][4:0]  src_addr;
  logic [3:0]       src_haz;
  logic             vd_clr;
  logic             waw_haz;
  logic             accept;

  assign src_addr = {5'd0, bus.iss_vs3, bus.iss_vs2, bus.iss_vs1};

  // Only write port 0 forwards in time to satisfy a source this cycle.
  always_comb begin
    src_haz = '0;
    for (int k = 0; k < 4; k++) begin
      src_haz[k] = bus.iss_use[k] && busy_q[src_addr[k]] &&
                   !(bus.wb_valid[0] && (bus.wb_addr[4:0] == src_addr[k]));
    end
    if (bus.iss_sc_en) src_haz[0] = 1'b0;
  end

  always_comb begin
    vd_clr = 1'b0;
    for (int i = 0; i < WPORT; i++) begin
      if (bus.wb_valid[i] && (bus.wb_addr[i*5 +: 5] == bus.iss_vd)) vd_clr = 1'b1;
    end
  end

  assign waw_haz       = bus.iss_wb && busy_q[bus.iss_vd] && !vd_clr;
  assign bus.iss_ready = !rst && (!v_q || bus.ex_ready) && !(|src_haz) && !waw_haz;
  assign accept        = bus.iss_valid && bus.iss_ready;

  assign bus.vrf_rd_en   = accept ? (bus.iss_use & {3'b111, !bus.iss_sc_en}) : 4'b0000;
  assign bus.vrf_rd_addr = src_addr;

  always_comb begin
    case (bus.iss_sew)
      2'd0:    splat_d = {(XLEN/8){bus.iss_scalar[7:0]}};
      2'd1:    splat_d = {(XLEN/16){bus.iss_scalar[15:0]}};
      2'd2:    splat_d = {(XLEN/32){bus.iss_scalar[31:0]}};
      default: splat_d = {(XLEN/64){bus.iss_scalar[63:0]}};
    endcase
  end

  // Clears first, then the accepted writer's set so it wins over a same-edge clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < WPORT; i++) begin
      if (bus.wb_valid[i]) busy_d[bus.wb_addr[i*5 +: 5]] = 1'b0;
    end
    if (accept && bus.iss_wb) busy_d[bus.iss_vd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      v_q     <= 1'b0;
      tag_q   <= '0;
      use_q   <= '0;
      sc_en_q <= 1'b0;
      splat_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        v_q     <= 1'b1;
        tag_q   <= bus.iss_tag;
        use_q   <= bus.iss_use;
        sc_en_q <= bus.iss_sc_en;
        splat_q <= splat_d;
      end else if (bus.ex_ready) begin
        v_q <= 1'b0;
      end
    end
  end

  // VRF rd_data is held by the VRF while rd_en stays low, so operands are stable in a stall.
  assign bus.ex_valid = v_q;
  assign bus.ex_tag   = tag_q;
  assign bus.ex_use   = use_q;
  assign bus.ex_opnd0 = sc_en_q  ? splat_q :
                        use_q[0] ? bus.vrf_rd_data[0*XLEN +: XLEN] : '0;
  assign bus.ex_opnd1 = use_q[1] ? bus.vrf_rd_data[1*XLEN +: XLEN] : '0;
  assign bus.ex_opnd2 = use_q[2] ? bus.vrf_rd_data[2*XLEN +: XLEN] : '0;
  assign bus.ex_mask  = use_q[3] ? bus.vrf_rd_data[3*XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_vec_opnd_fetch.sv
// Directed bench for vec_opnd_fetch with a one-cycle registered VRF model.
module tb_vec_opnd_fetch;
  localparam int XLEN  = 512;
  localparam int WPORT = 4;
  localparam int TAG_W = 8;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  vec_opnd_fetch_if #(.XLEN(XLEN), .WPORT(WPORT), .TAG_W(TAG_W)) bus ();

  vec_opnd_fetch #(.XLEN(XLEN), .WPORT(WPORT), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each VRF port returns a tagged pattern of port number and register address.
  function automatic logic [XLEN-1:0] pat(input int k, input logic [4:0] a);
    logic [7:0] kb;
    kb = 8'(k);
    return {(XLEN/32){kb, 8'hC0, 11'd0, a}};
  endfunction

  logic [4*XLEN-1:0] vrf_q = '0;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.vrf_rd_en[k]) vrf_q[k*XLEN +: XLEN] <= pat(k, bus.vrf_rd_addr[k*5 +: 5]);
    end
  end
  assign bus.vrf_rd_data = vrf_q;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid  = 1'b0;
    bus.iss_tag    = '0;
    bus.iss_use    = 4'b0000;
    bus.iss_vs1    = 5'd0;
    bus.iss_vs2    = 5'd0;
    bus.iss_vs3    = 5'd0;
    bus.iss_sc_en  = 1'b0;
    bus.iss_scalar = 64'd0;
    bus.iss_sew    = 2'd0;
    bus.iss_wb     = 1'b0;
    bus.iss_vd     = 5'd0;
    bus.wb_valid   = '0;
    bus.wb_addr    = '0;
  endtask

  task automatic issue(input logic [7:0] tag, input logic [3:0] use_f, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic [4:0] vs3, input logic wb,
                       input logic [4:0] vd);
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_tag   = tag;
    bus.iss_use   = use_f;
    bus.iss_vs1   = vs1;
    bus.iss_vs2   = vs2;
    bus.iss_vs3   = vs3;
    bus.iss_wb    = wb;
    bus.iss_vd    = vd;
  endtask

  initial begin
    logic [XLEN-1:0] splat_exp;
    splat_exp = {(XLEN/16){16'hABCD}};

    // Reset with a valid writer pending: nothing may be read or accepted.
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    issue(8'd99, 4'b1111, 5'd1, 5'd2, 5'd9, 1'b1, 5'd9);
    #2;
    chk("rst_iss_ready", bus.iss_ready, 0);
    chk("rst_rd_en", bus.vrf_rd_en, 0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_ex_valid", bus.ex_valid, 0);
    chk("post_rst_ex_tag", bus.ex_tag, 0);

    // Back-to-back issue; second reads v9 which must not be busy after reset.
    tick();
    issue(8'd1, 4'b0011, 5'd3, 5'd4, 5'd0, 1'b0, 5'd0);
    #2;
    chk("b2b_ready0", bus.iss_ready, 1);
    chk("b2b_rd_en0", bus.vrf_rd_en, 4'b0011);
    chk("b2b_rd_addr0", bus.vrf_rd_addr[9:0], {5'd4, 5'd3});
    tick();
    issue(8'd2, 4'b0011, 5'd9, 5'd10, 5'd0, 1'b0, 5'd0);
    #2;
    chk("b2b_ready1", bus.iss_ready, 1);
    chk("b2b_ex_valid1", bus.ex_valid, 1);
    chk("b2b_ex_tag1", bus.ex_tag, 8'd1);
    chk("b2b_opnd0_1", bus.ex_opnd0, pat(0, 5'd3));
    chk("b2b_opnd1_1", bus.ex_opnd1, pat(1, 5'd4));
    chk("b2b_opnd2_1", bus.ex_opnd2, 0);
    chk("b2b_mask_1", bus.ex_mask, 0);
    tick();
    idle();
    #2;
    chk("b2b_ex_tag2", bus.ex_tag, 8'd2);
    chk("b2b_opnd0_2", bus.ex_opnd0, pat(0, 5'd9));
    chk("b2b_opnd1_2", bus.ex_opnd1, pat(1, 5'd10));
    tick();
    #2;
    chk("drain_ex_valid", bus.ex_valid, 0);

    // vs3 and mask path: port 3 always reads v0.
    issue(8'd20, 4'b1100, 5'd0, 5'd0, 5'd11, 1'b0, 5'd0);
    #2;
    chk("mask_rd_en", bus.vrf_rd_en, 4'b1100);
    chk("mask_rd_addr", bus.vrf_rd_addr[19:10], {5'd0, 5'd11});
    tick();
    idle();
    #2;
    chk("mask_opnd2", bus.ex_opnd2, pat(2, 5'd11));
    chk("mask_mask", bus.ex_mask, pat(3, 5'd0));
    chk("mask_opnd0", bus.ex_opnd0, 0);

    // RAW on v5 cleared by write port 2: readable only the cycle after.
    tick();
    issue(8'd3, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5);
    tick();
    issue(8'd4, 4'b0010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0);
    #2;
    chk("raw_ready_busy", bus.iss_ready, 0);
    chk("raw_rd_en_busy", bus.vrf_rd_en, 0);
    tick();
    bus.wb_valid = 4'b0100;
    bus.wb_addr  = {5'd0, 5'd5, 5'd0, 5'd0};
    #2;
    chk("raw_ready_wb2_same", bus.iss_ready, 0);
    tick();
    bus.wb_valid = '0;
    #2;
    chk("raw_ready_wb2_next", bus.iss_ready, 1);
    chk("raw_rd_en_wb2_next", bus.vrf_rd_en, 4'b0010);
    tick();

    // Same RAW cleared by write port 0: forwarded in the same cycle.
    issue(8'd5, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5);
    tick();
    issue(8'd6, 4'b0010, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0);
    bus.wb_valid = 4'b0001;
    bus.wb_addr  = {5'd0, 5'd0, 5'd0, 5'd5};
    #2;
    chk("raw_ready_wb0_same", bus.iss_ready, 1);
    tick();

    // Scalar splat at SEW=16, then a 3-cycle execute stall.
    issue(8'd7, 4'b0001, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0);
    bus.iss_sc_en  = 1'b1;
    bus.iss_sew    = 2'd1;
    bus.iss_scalar = 64'h1234_5678_9ABC_ABCD;
    #2;
    chk("splat_ready", bus.iss_ready, 1);
    chk("splat_rd_en", bus.vrf_rd_en, 0);
    tick();
    issue(8'd8, 4'b0011, 5'd6, 5'd8, 5'd0, 1'b0, 5'd0);
    bus.ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stall_ready", bus.iss_ready, 0);
      chk("stall_rd_en", bus.vrf_rd_en, 0);
      chk("stall_ex_valid", bus.ex_valid, 1);
      chk("stall_ex_tag", bus.ex_tag, 8'd7);
      chk("stall_opnd0_splat", bus.ex_opnd0, splat_exp);
      tick();
    end
    bus.ex_ready = 1'b1;
    #2;
    chk("unstall_ready", bus.iss_ready, 1);
    chk("unstall_rd_en", bus.vrf_rd_en, 4'b0011);
    tick();
    idle();
    #2;
    chk("unstall_ex_tag", bus.ex_tag, 8'd8);
    chk("unstall_opnd0", bus.ex_opnd0, pat(0, 5'd6));
    chk("unstall_opnd1", bus.ex_opnd1, pat(1, 5'd8));
    tick();

    // WAW on v7 with a port-1 clear: accepted, and the new set wins.
    issue(8'd9, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7);
    tick();
    issue(8'd10, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7);
    bus.wb_valid = 4'b0010;
    bus.wb_addr  = {5'd0, 5'd0, 5'd7, 5'd0};
    #2;
    chk("waw_ready", bus.iss_ready, 1);
    tick();
    issue(8'd11, 4'b0001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0);
    #2;
    chk("waw_busy_kept", bus.iss_ready, 0);
    tick();
    bus.wb_valid = 4'b0001;
    bus.wb_addr  = {5'd0, 5'd0, 5'd0, 5'd7};
    #2;
    chk("waw_cleanup_ready", bus.iss_ready, 1);
    tick();

    // Reset during a stall drops the held instruction.
    issue(8'd12, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    bus.ex_ready = 1'b0;
    tick();
    #2;
    chk("midstall_ex_valid", bus.ex_valid, 1);
    rst = 1'b1;
    #1;
    chk("midstall_rst_ready", bus.iss_ready, 0);
    chk("midstall_rst_rd_en", bus.vrf_rd_en, 0);
    tick();
    rst = 1'b0;
    idle();
    bus.ex_ready = 1'b1;
    #2;
    chk("midstall_after_valid", bus.ex_valid, 0);
    chk("midstall_after_tag", bus.ex_tag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vec_opnd_fetch.md
Name: vec_opnd_fetch

Overview:
Operand-fetch stage between the vector issue queue and the execution units. It accepts one vector instruction per cycle and checks source and destination registers against a 32-entry pending-write scoreboard. It then drives up to four VRF read ports and presents the collected operands, including a scalar splat for .vx/.vi forms, to execution over a valid/ready handshake. VRF read latency is one cycle (registered rd_data). Only write port 0 is forwarded in the same cycle.

Parameters:
XLEN, 512, vector register width in bits (multiple of 64)
WPORT, 4, VRF write/writeback ports observed for scoreboard clear
TAG_W, 8, instruction tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
iss_valid  in  1  issue request
iss_ready  out  1  stage accepts issue this cycle
iss_tag  in  TAG_W  instruction tag
iss_use  in  4  operand-used flags: [0] vs1, [1] vs2, [2] vs3/old-vd, [3] v0 mask
iss_vs1, iss_vs2, iss_vs3  in  5 each  source register addresses
iss_sc_en  in  1  operand 0 is scalar splat, not vs1
iss_scalar  in  64  scalar/immediate value
iss_sew  in  2  element width: 0=8, 1=16, 2=32, 3=64
iss_wb  in  1  instruction writes vd
iss_vd  in  5  destination register
wb_valid  in  WPORT  writeback happening on VRF write port i
wb_addr  in  WPORT*5  writeback register per port
vrf_rd_en  out  4  VRF read enables
vrf_rd_addr  out  4*5  VRF read addresses
vrf_rd_data  in  4*XLEN  VRF read data, valid one cycle after rd_en
ex_valid  out  1  operands valid
ex_ready  in  1  execution accepts
ex_tag  out  TAG_W
ex_use  out  4
ex_opnd0, ex_opnd1, ex_opnd2, ex_mask  out  XLEN each  operands

Behaviour:
- State: busy[31:0] scoreboard; output stage holds v_q, tag, use, sc_en, splat register.
- Source hazard k (k=0..2, plus port 3 at address 0): use[k] && busy[addr_k] && !(wb_valid[0] && wb_addr[0]==addr_k).
  - Operand 0 with iss_sc_en=1 is never a hazard.
  - A clear on port 1..3 in the same cycle does NOT remove the hazard; that operand is readable next cycle.
- WAW hazard: iss_wb && busy[iss_vd] && no wb_valid[i] with wb_addr[i]==iss_vd this cycle.
- iss_ready = !rst && (!v_q || ex_ready) && no hazard. Accept = iss_valid && iss_ready.
- Read drive (combinational):
  - vrf_rd_en[k] = accept && use[k], with rd_en[0] also requiring !iss_sc_en.
  - Addresses: port 0 = vs1, port 1 = vs2, port 2 = vs3, port 3 = 5'd0.
  - Non-accepting cycles drive rd_en=0; this keeps VRF rd_data held during stalls.
- Latency: accept in cycle t gives ex_valid=1 in cycle t+1. Full throughput, one instruction per cycle.
- ex_opndN = vrf_rd_data[N] when the registered use bit is set, else 0. ex_mask follows the same rule on port 3.
- Scalar splat: ex_opnd0 = iss_scalar[SEW-1:0] replicated across XLEN, captured into the splat register at accept.
- ex handshake: v_q is set on accept and cleared on ex_ready without a new accept. Outputs stay stable while v_q && !ex_ready.
- Scoreboard, same edge:
  - Clear busy[wb_addr[i]] for every wb_valid[i].
  - Then set busy[iss_vd] on accept && iss_wb. Set wins over clear.
- Duplicate wb addresses are legal. A wb to a non-busy register has no effect.
- Reset:
  - busy=0, v_q=0, ex_valid=0; tag, use, splat and ex_* registers = 0.
  - vrf_rd_en=0 and iss_ready=0 while rst=1.
  - Reset mid-stall discards the held instruction. No read issues in the reset cycle.

Test Plan:
- Reset with iss_valid=1: iss_ready=0, vrf_rd_en=0. After release, busy=0 and ex_valid=0.
- Back-to-back issue of vs1=3, vs2=4 with use=0011, ex_ready=1 -> rd_en=0011 and addresses 3/4 in cycle t. ex_valid in t+1 carries VRF data, ex_opnd2=0 and ex_mask=0. Two instructions complete in two cycles.
- Issue vd=5 with wb, then issue vs2=5 -> iss_ready=0.
  - wb_valid[2] for 5 -> accepted one cycle later.
  - Repeat with wb_valid[0] for 5 -> accepted in the same cycle.
- iss_sc_en=1, sew=1, scalar=0x...ABCD -> rd_en[0]=0 and ex_opnd0 = 0xABCD repeated 32 times at XLEN=512.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, iss_ready=0, rd_en=0. ex_ready=1 -> next instruction accepted that cycle.
- Same-cycle wb_valid[1] for vd=7 and issue with wb vd=7 while busy[7]=1 -> accepted, busy[7] remains 1.
